// File: rtl/reg_file_inc.sv
// Shared types and constants for the RV32 integer register file and its users.
package reg_file_inc;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REGISTER_X0 = 5'd0;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
  } reg_file_read_params_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } reg_file_wb_pkt_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: one outstanding writer per register, with
// hazard detection that treats a same-cycle writeback as already resolved.
module reg_scoreboard
  import reg_file_inc::*;
#(
  parameter int NUM_REGS = reg_file_inc::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  reg_idx_t            rs1,
  input  reg_idx_t            rs2,
  input  reg_idx_t            rd,
  input  logic                query_rd,
  input  logic                set_en,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  input  logic                flush,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  function automatic logic wb_hit(input logic en, input reg_idx_t wb_idx,
                                  input reg_idx_t idx);
    return en && (wb_idx == idx) && (idx != REGISTER_X0);
  endfunction

  always_comb begin
    hazard = 1'b0;
    if (busy_q[rs1] && !wb_hit(clr_en, clr_idx, rs1)) hazard = 1'b1;
    if (busy_q[rs2] && !wb_hit(clr_en, clr_idx, rs2)) hazard = 1'b1;
    if (query_rd && busy_q[rd] && !wb_hit(clr_en, clr_idx, rd)) hazard = 1'b1;
  end

  // Priority: flush > set > clear, so a new writer outlives a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_idx != REGISTER_X0)) busy_d[clr_idx] = 1'b0;
    if (set_en && (rd != REGISTER_X0))      busy_d[rd]      = 1'b1;
    if (flush)                              busy_d          = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/reg_file_rw.sv
// RV32 architectural register file: registered operand reads with writeback
// bypass, busy-scoreboard stalling, and pipeline flush.
module reg_file_rw
  import reg_file_inc::*;
#(
  parameter int XLEN     = reg_file_inc::XLEN,
  parameter int NUM_REGS = reg_file_inc::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  reg_file_read_params_t req_params,
  input  logic                  req_writes_rd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_rs1_data,
  output logic [XLEN-1:0]       rsp_rs2_data,
  output reg_idx_t              rsp_rd,
  input  logic                  wb_valid,
  input  reg_idx_t              wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy_mask
);

  logic [XLEN-1:0] regs [NUM_REGS];

  logic            hazard;
  logic            accept_p0;
  logic            wb_we;
  logic [XLEN-1:0] rs1_op_p0;
  logic [XLEN-1:0] rs2_op_p0;

  logic            vld_p1;
  logic [XLEN-1:0] rs1_data_p1;
  logic [XLEN-1:0] rs2_data_p1;
  reg_idx_t        rd_p1;

  assign wb_we     = wb_valid && (wb_rd != REGISTER_X0);
  assign req_ready = (!vld_p1 || rsp_ready) && !hazard && !flush;
  assign accept_p0 = req_valid && req_ready;

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1       (req_params.rs1),
    .rs2       (req_params.rs2),
    .rd        (req_params.rd),
    .query_rd  (req_writes_rd),
    .set_en    (accept_p0 && req_writes_rd),
    .clr_en    (wb_valid),
    .clr_idx   (wb_rd),
    .flush     (flush),
    .hazard    (hazard),
    .busy_mask (busy_mask)
  );

  // Operand select: x0 forces zero, otherwise a same-cycle writeback beats the array.
  always_comb begin
    rs1_op_p0 = regs[req_params.rs1];
    if (wb_we && (wb_rd == req_params.rs1)) rs1_op_p0 = wb_data;
    if (req_params.rs1 == REGISTER_X0)      rs1_op_p0 = '0;
    rs2_op_p0 = regs[req_params.rs2];
    if (wb_we && (wb_rd == req_params.rs2)) rs2_op_p0 = wb_data;
    if (req_params.rs2 == REGISTER_X0)      rs2_op_p0 = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Stage p0 -> p1: response register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      rd_p1       <= REGISTER_X0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1      <= 1'b1;
      rs1_data_p1 <= rs1_op_p0;
      rs2_data_p1 <= rs2_op_p0;
      rd_p1       <= req_params.rd;
    end else if (rsp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid    = vld_p1;
  assign rsp_rs1_data = rs1_data_p1;
  assign rsp_rs2_data = rs2_data_p1;
  assign rsp_rd       = rd_p1;

endmodule

// File: tb/tb_reg_file_rw.sv
// Directed self-checking bench for reg_file_rw.
module tb_reg_file_rw;
  import reg_file_inc::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  reg_file_read_params_t req_params;
  logic                  req_writes_rd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rs1_data;
  logic [31:0]           rsp_rs2_data;
  reg_idx_t              rsp_rd;
  logic                  wb_valid;
  reg_idx_t              wb_rd;
  logic [31:0]           wb_data;
  logic                  flush;
  logic [31:0]           busy_mask;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  reg_file_rw dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_params    (req_params),
    .req_writes_rd (req_writes_rd),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rs1_data  (rsp_rs1_data),
    .rsp_rs2_data  (rsp_rs2_data),
    .rsp_rd        (rsp_rd),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .busy_mask     (busy_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req_valid     = 1'b0;
    req_params    = '0;
    req_writes_rd = 1'b0;
    rsp_ready     = 1'b1;
    wb_valid      = 1'b0;
    wb_rd         = 5'd0;
    wb_data       = '0;
    flush         = 1'b0;
  endtask

  task automatic drive_req(input int rs1, input int rs2, input int rd, input logic wr);
    req_valid      = 1'b1;
    req_params.rs1 = reg_idx_t'(rs1);
    req_params.rs2 = reg_idx_t'(rs2);
    req_params.rd  = reg_idx_t'(rd);
    req_writes_rd  = wr;
  endtask

  task automatic drive_wb(input int rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_rd    = reg_idx_t'(rd);
    wb_data  = data;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    drive_req(5, 0, 7, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    set_idle();
    #1;
    total_cnt++; if (busy_mask !== 32'h0) $display("FAIL reset_busy: got %h want %h", busy_mask, 32'h0); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rs1_data !== 32'h0 || rsp_rd !== 5'd0) $display("FAIL reset_rsp_data: got %h/%0d want 0/0", rsp_rs1_data, rsp_rd); else pass_cnt++;
    drive_req(5, 0, 0, 1'b0);
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL first_ready: got %b want 1", req_ready); else pass_cnt++;
    tick();
    set_idle();
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h0) $display("FAIL first_read: got v=%b %h %h want v=1 0 0", rsp_valid, rsp_rs1_data, rsp_rs2_data); else pass_cnt++;
    tick();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rsp_drain: got %b want 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_writeback();
    drive_wb(5, 32'hDEADBEEF);
    tick();
    set_idle();
    drive_req(5, 0, 2, 1'b0);
    tick();
    set_idle();
    total_cnt++; if (rsp_rs1_data !== 32'hDEADBEEF || rsp_rd !== 5'd2) $display("FAIL wb_read_x5: got %h rd=%0d want deadbeef rd=2", rsp_rs1_data, rsp_rd); else pass_cnt++;
    drive_wb(0, 32'h1234);
    tick();
    set_idle();
    drive_req(0, 0, 0, 1'b0);
    tick();
    set_idle();
    total_cnt++; if (rsp_rs1_data !== 32'h0) $display("FAIL x0_write_ignored: got %h want 0", rsp_rs1_data); else pass_cnt++;
    total_cnt++; if (busy_mask !== 32'h0) $display("FAIL x0_busy: got %h want 0", busy_mask); else pass_cnt++;
  endtask

  task automatic test_raw_bypass();
    drive_req(0, 0, 7, 1'b1);
    tick();
    set_idle();
    total_cnt++; if (busy_mask !== 32'h0000_0080) $display("FAIL raw_busy_set: got %h want 00000080", busy_mask); else pass_cnt++;
    drive_req(0, 7, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL raw_stall: got %b want 0", req_ready); else pass_cnt++;
      tick();
    end
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL raw_no_rsp: got %b want 0", rsp_valid); else pass_cnt++;
    drive_wb(7, 32'hCAFEF00D);
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL raw_ready_on_wb: got %b want 1", req_ready); else pass_cnt++;
    tick();
    set_idle();
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_rs2_data !== 32'hCAFEF00D) $display("FAIL raw_bypass: got v=%b %h want v=1 cafef00d", rsp_valid, rsp_rs2_data); else pass_cnt++;
    total_cnt++; if (busy_mask !== 32'h0) $display("FAIL raw_busy_clr: got %h want 0", busy_mask); else pass_cnt++;
    tick();
  endtask

  task automatic test_waw_set_wins();
    drive_req(0, 0, 3, 1'b1);
    drive_wb(3, 32'h33);
    tick();
    set_idle();
    total_cnt++; if (busy_mask !== 32'h0000_0008) $display("FAIL set_wins: got %h want 00000008", busy_mask); else pass_cnt++;
    drive_req(0, 0, 3, 1'b1);
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL waw_stall: got %b want 0", req_ready); else pass_cnt++;
    tick();
    set_idle();
    total_cnt++; if (rsp_valid !== 1'b0 || busy_mask !== 32'h8) $display("FAIL waw_no_accept: got v=%b busy=%h want v=0 busy=00000008", rsp_valid, busy_mask); else pass_cnt++;
    drive_wb(3, 32'h333);
    tick();
    set_idle();
    total_cnt++; if (busy_mask !== 32'h0) $display("FAIL waw_clear: got %h want 0", busy_mask); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    drive_req(5, 3, 9, 1'b0);
    tick();
    drive_req(3, 5, 10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL hold_ready: got %b want 0", req_ready); else pass_cnt++;
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hDEADBEEF || rsp_rs2_data !== 32'h333 || rsp_rd !== 5'd9) $display("FAIL hold_stable: got v=%b %h %h rd=%0d want v=1 deadbeef 00000333 rd=9", rsp_valid, rsp_rs1_data, rsp_rs2_data, rsp_rd); else pass_cnt++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", req_ready); else pass_cnt++;
    tick();
    set_idle();
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'h333 || rsp_rs2_data !== 32'hDEADBEEF || rsp_rd !== 5'd10) $display("FAIL b2b_data: got v=%b %h %h rd=%0d want v=1 00000333 deadbeef rd=10", rsp_valid, rsp_rs1_data, rsp_rs2_data, rsp_rd); else pass_cnt++;
    tick();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    drive_req(0, 0, 4, 1'b1);
    tick();
    drive_req(0, 0, 9, 1'b1);
    tick();
    set_idle();
    rsp_ready = 1'b0;
    #1;
    total_cnt++; if (busy_mask !== 32'h0000_0210 || rsp_valid !== 1'b1) $display("FAIL flush_setup: got busy=%h v=%b want busy=00000210 v=1", busy_mask, rsp_valid); else pass_cnt++;
    flush = 1'b1;
    drive_wb(4, 32'h55);
    drive_req(0, 0, 0, 1'b0);
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", req_ready); else pass_cnt++;
    tick();
    set_idle();
    total_cnt++; if (busy_mask !== 32'h0 || rsp_valid !== 1'b0) $display("FAIL flush_clear: got busy=%h v=%b want busy=0 v=0", busy_mask, rsp_valid); else pass_cnt++;
    drive_req(4, 9, 1, 1'b0);
    tick();
    set_idle();
    total_cnt++; if (rsp_rs1_data !== 32'h55 || rsp_rs2_data !== 32'h0) $display("FAIL flush_wb_kept: got %h %h want 00000055 0", rsp_rs1_data, rsp_rs2_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    drive_req(5, 0, 6, 1'b1);
    tick();
    set_idle();
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_idle();
    total_cnt++; if (busy_mask !== 32'h0 || rsp_valid !== 1'b0 || rsp_rs1_data !== 32'h0) $display("FAIL reset_mid: got busy=%h v=%b d=%h want 0 0 0", busy_mask, rsp_valid, rsp_rs1_data); else pass_cnt++;
    drive_req(5, 4, 0, 1'b0);
    tick();
    set_idle();
    total_cnt++; if (rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h0) $display("FAIL reset_array: got %h %h want 0 0", rsp_rs1_data, rsp_rs2_data); else pass_cnt++;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_writeback();
    test_raw_bypass();
    test_waw_set_wins();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_rw.md
Name: reg_file_rw

Overview:
- Architectural integer register file for the RV32 core, on the responder side of the decode read interface.
- Accepts a `reg_file_read_params_t` request (rs1/rs2/rd) from decode, returns registered operand data one cycle later, and accepts writeback from the back end.
- Contains a per-register busy scoreboard, so reads stall while an older instruction still has a write to that register outstanding.
- Includes a writeback-to-read bypass and a pipeline flush.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, architectural register count; index width = $clog2(NUM_REGS) = 5.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  decode presents a read request
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_params  in  reg_file_read_params_t  rs1, rs2, rd (5b each)
- req_writes_rd  in  1  instruction will write rd
- rsp_valid  out  1  operand data valid
- rsp_ready  in  1  consumer takes the response
- rsp_rs1_data  out  XLEN  rs1 operand
- rsp_rs2_data  out  XLEN  rs2 operand
- rsp_rd  out  5  rd index, passed through
- wb_valid  in  1  writeback strobe
- wb_rd  in  5  writeback register index
- wb_data  in  XLEN  writeback value
- flush  in  1  discard in-flight state
- busy_mask  out  NUM_REGS  scoreboard state, for debug and verification

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all registers cleared to 0;
  - busy_mask=0;
  - rsp_valid=0;
  - rsp_rs1_data, rsp_rs2_data and rsp_rd all 0.
- x0 rules:
  - x0 reads as 0;
  - writes to x0 are ignored;
  - busy[0] is never set.
- Hazard definition. For each index r, wb_hit(r) = wb_valid & wb_rd==r & r!=0. hazard is true if any of the following holds:
  - busy[rs1] & !wb_hit(rs1);
  - busy[rs2] & !wb_hit(rs2);
  - req_writes_rd & busy[rd] & !wb_hit(rd). This is the WAW case: only one outstanding writer is allowed per register.
- Ready: req_ready = (!rsp_valid | rsp_ready) & !hazard & !flush. This is purely combinational from state and inputs, with no dependency on req_valid.
- Accept (req_valid & req_ready), effective at the next edge:
  - rsp_valid←1 and rsp_rd←rd.
  - Each operand is taken from wb_data if wb_hit(rsN), otherwise from the array. Index 0 always gives 0.
  - Latency is 1 cycle from accept to rsp_valid.
- Response holding:
  - If rsp_valid & !rsp_ready, all rsp_* outputs are held stable.
  - If rsp_ready is high with no new accept, rsp_valid←0.
- Writeback:
  - If wb_valid & wb_rd!=0, then array[wb_rd]←wb_data and busy[wb_rd]←0.
  - A writeback to a non-busy register is legal: the array is written and busy stays 0.
- Scoreboard set: on accept with req_writes_rd & rd!=0, busy[rd]←1.
  - If a same-cycle writeback targets the same rd, the set wins, because the new writer is now outstanding.
- Flush:
  - busy_mask←0 and rsp_valid←0; req_ready is 0 that cycle.
  - A same-cycle writeback still writes the array.
  - Flush overrides any set or clear of busy bits that cycle.
- Reset asserted mid-handshake discards the response and the scoreboard with no residual state.

Decomposition:
- Shared package `reg_file_inc`:
  - `REGISTER_X0`, XLEN;
  - `reg_idx_t` (5b);
  - `reg_file_read_params_t`;
  - the writeback packet typedef {valid, rd, data}.
- One sub-module, `reg_scoreboard`:
  - contains the busy vector, the set/clear/flush priority and the hazard computation;
  - inputs are indices plus a query/set/clear/flush interface;
  - outputs are hazard and busy_mask.
- The top level holds the array, the bypass mux and the response register.

Test Plan:
- Reset → busy_mask=0, rsp_valid=0. Then read rs1=x5, rs2=x0 → both data 0 one cycle after accept.
- Writeback x5=0xDEADBEEF, then a read with rs1=x5 → rsp_rs1_data=0xDEADBEEF. Writeback to x0 with 0x1234, then read x0 → 0.
- Accept a req with rd=x7, req_writes_rd=1 → busy_mask[7]=1. Next request rs2=x7 → req_ready=0 until a writeback to x7. On the writeback cycle itself, req_ready=1 and rsp_rs2_data equals wb_data (bypass).
- Same-cycle accept of a rd=x3 write plus writeback to x3 → busy_mask[3] stays 1. A request with rd=x3, req_writes_rd=1 while busy[3] → stalls (WAW).
- rsp_ready=0 for 3 cycles with rsp_valid=1 → outputs stable and req_ready=0. Then rsp_ready=1 with req_valid=1 → back-to-back accept, and rsp_valid stays 1 with the new data.
- busy on x4 and x9, then flush with a writeback to x4 (0x55) in the same cycle → busy_mask=0, rsp_valid=0, and a later read of x4 returns 0x55.
